// File: rtl/nvdla_cvt_arb_pkg.sv
// Shared constants for the fp16->fp32 converter arbiter.
//   FP16_W / FP32_W : operand and result payload widths
//   tag_width()     : width of a requester index tag for a given NREQ
package nvdla_cvt_arb_pkg;

  localparam int FP16_W   = 16;
  localparam int FP32_W   = 32;
  localparam int NREQ_MAX = 8;

  // A tag must be at least one bit wide even for degenerate requester counts.
  function automatic int tag_width(input int nreq);
    return (nreq <= 1) ? 1 : $clog2(nreq);
  endfunction

endpackage

// File: rtl/nvdla_fp16_to_fp32_arb_if.sv
// Handshake bundle between the requesters, the arbiter and the shared
// fp16->fp32 converter.
//   req_*     : per-requester request channel (valid/ready/fp16 payload)
//   cvt_in_*  : converter input channel (chn_a)
//   cvt_out_* : converter output channel (chn_o)
//   rsp_*     : per-requester response channel (one-hot valid, broadcast pd)
// slave  : the arbiter's view
// master : the surrounding environment's view (requesters + converter)
interface nvdla_fp16_to_fp32_arb_if
  import nvdla_cvt_arb_pkg::*;
#(
  parameter int NREQ = 4
);

  logic [NREQ-1:0]        req_vld;
  logic [NREQ-1:0]        req_rdy;
  logic [NREQ*FP16_W-1:0] req_pd;
  logic                   cvt_in_vld;
  logic                   cvt_in_rdy;
  logic [FP16_W-1:0]      cvt_in_pd;
  logic                   cvt_out_vld;
  logic                   cvt_out_rdy;
  logic [FP32_W-1:0]      cvt_out_pd;
  logic [NREQ-1:0]        rsp_vld;
  logic [NREQ-1:0]        rsp_rdy;
  logic [FP32_W-1:0]      rsp_pd;

  modport slave (
    input  req_vld, req_pd, cvt_in_rdy, cvt_out_vld, cvt_out_pd, rsp_rdy,
    output req_rdy, cvt_in_vld, cvt_in_pd, cvt_out_rdy, rsp_vld, rsp_pd
  );

  modport master (
    output req_vld, req_pd, cvt_in_rdy, cvt_out_vld, cvt_out_pd, rsp_rdy,
    input  req_rdy, cvt_in_vld, cvt_in_pd, cvt_out_rdy, rsp_vld, rsp_pd
  );

endinterface

// File: rtl/nvdla_cvt_tag_fifo.sv
// In-order tag FIFO: records which requester owns each in-flight conversion.
//   clk_i, rst_ni : clock, async active-low reset
//   push_i/din_i  : write a tag (caller guarantees not full)
//   pop_i         : drop the head tag (caller guarantees not empty)
//   dout_o        : head tag
//   full_o/empty_o/count_o : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module nvdla_cvt_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           din_i,
  output logic [W-1:0]           dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    // Push and pop together leave the occupancy unchanged.
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; entries are only read while counted as valid.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/nvdla_fp16_to_fp32_arb.sv
// Round-robin arbiter sharing one fp16->fp32 converter among NREQ requesters.
//   nvdla_core_clk, nvdla_core_rstn : clock, async active-low reset
//   bus        : request / converter / response handshakes (slave view)
//   inflight   : number of conversions issued but not yet returned
//   err_orphan : sticky flag, a converter result arrived with no owner tag
// Requests are granted combinationally; each accepted request's index is
// queued so converter results are routed back in issue order.
module nvdla_fp16_to_fp32_arb
  import nvdla_cvt_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DEPTH = 4
) (
  input  logic                    nvdla_core_clk,
  input  logic                    nvdla_core_rstn,
  nvdla_fp16_to_fp32_arb_if.slave bus,
  output logic [$clog2(DEPTH):0]  inflight,
  output logic                    err_orphan
);

  localparam int TAG_W = tag_width(NREQ);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             lock_q, lock_d;
  logic [TAG_W-1:0] lock_idx_q, lock_idx_d;
  logic             err_orphan_q, err_orphan_d;

  logic [TAG_W-1:0] rr_grant;
  logic [TAG_W-1:0] rr_idx;
  logic             rr_found;
  logic [TAG_W-1:0] grant;
  logic [TAG_W-1:0] head;
  logic             head_rdy;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             fire_in;
  logic             fire_out;

  // Round-robin search: first valid requester at or after rr_ptr, mod NREQ.
  always_comb begin
    rr_grant = rr_ptr_q;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      rr_idx = TAG_W'((int'(rr_ptr_q) + k) % NREQ);
      if (!rr_found && bus.req_vld[rr_idx]) begin
        rr_found = 1'b1;
        rr_grant = rr_idx;
      end
    end
  end

  // A stalled offer keeps its grant so the converter sees a stable payload.
  assign grant = lock_q ? lock_idx_q : rr_grant;

  // A full tag FIFO blocks new work even if a result drains this cycle.
  assign bus.cvt_in_vld = (|bus.req_vld) & ~full;
  assign fire_in        = bus.cvt_in_vld & bus.cvt_in_rdy;
  assign fire_out       = bus.cvt_out_vld & bus.cvt_out_rdy;

  always_comb begin
    bus.req_rdy   = '0;
    bus.cvt_in_pd = '0;
    bus.rsp_vld   = '0;
    head_rdy      = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == TAG_W'(i)) begin
        bus.req_rdy[i] = fire_in;
        bus.cvt_in_pd  = bus.req_pd[i*FP16_W +: FP16_W];
      end
      if (head == TAG_W'(i)) begin
        bus.rsp_vld[i] = bus.cvt_out_vld & ~empty;
        head_rdy       = bus.rsp_rdy[i];
      end
    end
  end

  assign bus.cvt_out_rdy = ~empty & head_rdy;
  assign bus.rsp_pd      = bus.cvt_out_pd;

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_d       = lock_q;
    lock_idx_d   = lock_idx_q;
    err_orphan_d = err_orphan_q | (bus.cvt_out_vld & empty);
    if (fire_in) begin
      lock_d   = 1'b0;
      rr_ptr_d = (grant == TAG_W'(NREQ - 1)) ? '0 : grant + 1'b1;
    end else if (bus.cvt_in_vld) begin
      lock_d     = 1'b1;
      lock_idx_d = grant;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      rr_ptr_q     <= '0;
      lock_q       <= 1'b0;
      lock_idx_q   <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_q       <= lock_d;
      lock_idx_q   <= lock_idx_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  nvdla_cvt_tag_fifo #(
    .DEPTH (DEPTH),
    .W     (TAG_W)
  ) u_tag_fifo (
    .clk_i   (nvdla_core_clk),
    .rst_ni  (nvdla_core_rstn),
    .push_i  (fire_in),
    .pop_i   (fire_out),
    .din_i   (grant),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign inflight   = count;
  assign err_orphan = err_orphan_q;

endmodule
